// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel clock/enable, raster position, blanking,
// sync and line/frame strobes. The generator drives it; consumers listen.
interface vga_timing_gen_if #(
  parameter int W_X = 10,
  parameter int W_Y = 10
);
  logic           pixel_clk;
  logic           pixel_en;
  logic [W_X-1:0] hpos;
  logic [W_Y-1:0] vpos;
  logic           display_on;
  logic           hsync;
  logic           vsync;
  logic           line_start;
  logic           frame_start;

  modport master (
    output pixel_clk, pixel_en, hpos, vpos, display_on,
           hsync, vsync, line_start, frame_start
  );

  modport slave (
    input  pixel_clk, pixel_en, hpos, vpos, display_on,
           hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. Divides clk by R = CLK_MHZ/PIXEL_MHZ
// into a pixel clock and pixel enable, and walks hpos/vpos across the full
// raster. Every output is a flop loaded from the next-state counters, so
// sync/blank/strobes always agree with the hpos/vpos shown in that cycle.
// The interface instance must be built with the same W_X/W_Y as this module.
module vga_timing_gen #(
  parameter int CLK_MHZ   = 50,
  parameter int PIXEL_MHZ = 25,
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int W_X       = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
  parameter int W_Y       = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_timing_gen_if.master    vid
);

  localparam int R       = CLK_MHZ / PIXEL_MHZ;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int W_D     = (R < 2) ? 1 : $clog2(R);

  localparam logic [W_D-1:0] DIV_LAST = W_D'(R - 1);
  localparam logic [W_D-1:0] DIV_HALF = W_D'(R / 2);

  localparam logic [W_X-1:0] H_LAST   = W_X'(H_TOTAL - 1);
  localparam logic [W_X-1:0] H_ACT    = W_X'(H_ACTIVE);
  localparam logic [W_X-1:0] HS_FIRST = W_X'(H_ACTIVE + H_FRONT);
  localparam logic [W_X-1:0] HS_LAST  = W_X'(H_ACTIVE + H_FRONT + H_SYNC - 1);

  localparam logic [W_Y-1:0] V_LAST   = W_Y'(V_TOTAL - 1);
  localparam logic [W_Y-1:0] V_ACT    = W_Y'(V_ACTIVE);
  localparam logic [W_Y-1:0] VS_FIRST = W_Y'(V_ACTIVE + V_FRONT);
  localparam logic [W_Y-1:0] VS_LAST  = W_Y'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  if (R < 2 || R * PIXEL_MHZ != CLK_MHZ) begin : g_bad_ratio
    $error("vga_timing_gen: CLK_MHZ/PIXEL_MHZ must be an integer >= 2");
  end
  if (H_SYNC < 1 || H_BACK < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_porch
    $error("vga_timing_gen: SYNC and BACK parameters must be >= 1");
  end

  logic [W_D-1:0] div_q, div_d;
  logic [W_X-1:0] hpos_q, hpos_d;
  logic [W_Y-1:0] vpos_q, vpos_d;
  logic           pixel_clk_q, pixel_clk_d;
  logic           pixel_en_q, pixel_en_d;
  logic           display_on_q, display_on_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           pix_step;

  // Next-state counters, then every output decoded from the next state so
  // the registered outputs line up with the registered position.
  always_comb begin
    pix_step      = (div_q == DIV_LAST);
    div_d         = pix_step ? '0 : div_q + 1'b1;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_step) begin
      if (hpos_q == H_LAST) begin
        hpos_d       = '0;
        line_start_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d        = '0;
          frame_start_d = 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
    // pixel_en/pixel_clk are registered too, decoded from div_d so they
    // track div exactly without a combinational path to the pins.
    pixel_en_d   = (div_d == DIV_LAST);
    pixel_clk_d  = (div_d >= DIV_HALF);
    display_on_d = (hpos_d < H_ACT) && (vpos_d < V_ACT);
    hsync_d      = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? HS_ON : ~HS_ON;
    vsync_d      = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? VS_ON : ~VS_ON;
  end

  // State registers; reset parks the raster on its last position, which
  // lies in both back porches, so the reset outputs match the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      pixel_clk_q   <= 1'b0;
      pixel_en_q    <= 1'b0;
      display_on_q  <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      pixel_clk_q   <= pixel_clk_d;
      pixel_en_q    <= pixel_en_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.pixel_clk   = pixel_clk_q;
  assign vid.pixel_en    = pixel_en_q;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.display_on  = display_on_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny
// odd-ratio instance (R=3, 8x6 raster, active-high hsync).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n_def = 1'b0;
  logic rst_n_sml = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.W_X(10), .W_Y(10)) vd ();
  vga_timing_gen_if #(.W_X(3),  .W_Y(3))  vsm ();

  vga_timing_gen u_def (
    .clk   (clk),
    .rst_n (rst_n_def),
    .vid   (vd)
  );

  vga_timing_gen #(
    .CLK_MHZ(75), .PIXEL_MHZ(25),
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(0),
    .W_X(3), .W_Y(3)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_n_sml),
    .vid   (vsm)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // edges = clk edges to advance before checking the small instance
  typedef struct {
    int edges;
    int hpos, vpos, disp, hs, vs, pclk, pen, ls, fs;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    int first_hs, last_hs, first_blank, hs_low, pclk_hi, pen_hi, ls_cnt, fs_cnt;
    int disp_cnt, dbl_ls, dbl_fs, fs2_at, edges;
    bit found, prev_ls, prev_fs;

    //            edges hpos vpos disp hs vs pclk pen ls fs
    tbl[0]  = '{  0,    7,   5,   0,   0, 1, 0,   0,  0, 0};
    tbl[1]  = '{  1,    7,   5,   0,   0, 1, 1,   0,  0, 0};
    tbl[2]  = '{  1,    7,   5,   0,   0, 1, 1,   1,  0, 0};
    tbl[3]  = '{  1,    0,   0,   1,   0, 1, 0,   0,  1, 1};
    tbl[4]  = '{  1,    0,   0,   1,   0, 1, 1,   0,  0, 0};
    tbl[5]  = '{  11,   4,   0,   0,   0, 1, 0,   0,  0, 0};
    tbl[6]  = '{  3,    5,   0,   0,   1, 1, 0,   0,  0, 0};
    tbl[7]  = '{  3,    6,   0,   0,   1, 1, 0,   0,  0, 0};
    tbl[8]  = '{  3,    7,   0,   0,   0, 1, 0,   0,  0, 0};
    tbl[9]  = '{  3,    0,   1,   1,   0, 1, 0,   0,  1, 0};
    tbl[10] = '{  48,   0,   3,   0,   0, 1, 0,   0,  1, 0};
    tbl[11] = '{  24,   0,   4,   0,   0, 0, 0,   0,  1, 0};
    tbl[12] = '{  24,   0,   5,   0,   0, 1, 0,   0,  1, 0};
    tbl[13] = '{  24,   0,   0,   1,   0, 1, 0,   0,  1, 1};
    tbl[14] = '{  1,    0,   0,   1,   0, 1, 1,   0,  0, 0};
    tbl[15] = '{  56,   3,   2,   1,   0, 1, 0,   0,  0, 0};
    tbl[16] = '{  3,    4,   2,   0,   0, 1, 0,   0,  0, 0};
    tbl[17] = '{  2,    4,   2,   0,   0, 1, 1,   1,  0, 0};

    // ---------------- default mode: reset values ----------------
    repeat (3) tick();
    chk("def_rst_hpos", int'(vd.hpos), 799);
    chk("def_rst_vpos", int'(vd.vpos), 524);
    chk("def_rst_disp", int'(vd.display_on), 0);
    chk("def_rst_hsync", int'(vd.hsync), 1);
    chk("def_rst_vsync", int'(vd.vsync), 1);
    chk("def_rst_pclk", int'(vd.pixel_clk), 0);
    chk("def_rst_fs", int'(vd.frame_start), 0);

    @(negedge clk);
    rst_n_def = 1'b1;
    tick();
    chk("def_rel_edge1_fs", int'(vd.frame_start), 0);
    tick();
    chk("def_rel_edge2_fs", int'(vd.frame_start), 1);
    chk("def_rel_edge2_ls", int'(vd.line_start), 1);
    chk("def_rel_hpos", int'(vd.hpos), 0);
    chk("def_rel_vpos", int'(vd.vpos), 0);
    chk("def_rel_disp", int'(vd.display_on), 1);

    // ---------------- default mode: one full line ----------------
    first_hs = -1; last_hs = -1; first_blank = -1;
    hs_low = 0; pclk_hi = 0; pen_hi = 0; ls_cnt = 0;
    for (int c = 0; c < 1600; c++) begin
      if (vd.pixel_clk !== c[0]) chk("def_pclk_phase", int'(vd.pixel_clk), c % 2);
      if (vd.pixel_en  !== c[0]) chk("def_pen_phase", int'(vd.pixel_en), c % 2);
      if (vd.pixel_clk) pclk_hi++;
      if (vd.pixel_en)  pen_hi++;
      if (vd.line_start) ls_cnt++;
      if (!vd.hsync) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(vd.hpos);
        last_hs = int'(vd.hpos);
      end
      if (!vd.display_on && first_blank < 0) first_blank = int'(vd.hpos);
      tick();
    end
    chk("def_pclk_high_clks", pclk_hi, 800);
    chk("def_pen_count", pen_hi, 800);
    chk("def_ls_per_line", ls_cnt, 1);
    chk("def_hsync_low_clks", hs_low, 192);
    chk("def_hsync_first_hpos", first_hs, 656);
    chk("def_hsync_last_hpos", last_hs, 751);
    chk("def_blank_first_hpos", first_blank, 640);
    chk("def_line2_ls", int'(vd.line_start), 1);
    chk("def_line2_fs", int'(vd.frame_start), 0);
    chk("def_line2_hpos", int'(vd.hpos), 0);
    chk("def_line2_vpos", int'(vd.vpos), 1);

    // ---------------- default mode: mid-frame reset ----------------
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (vd.hpos == 10'd300) found = 1'b1;
      else tick();
    end
    chk("def_wait_hpos300", int'(found), 1);
    rst_n_def = 1'b0;
    #1;
    chk("def_midrst_hpos", int'(vd.hpos), 799);
    chk("def_midrst_vpos", int'(vd.vpos), 524);
    chk("def_midrst_disp", int'(vd.display_on), 0);
    chk("def_midrst_hsync", int'(vd.hsync), 1);
    fs_cnt = 0;
    repeat (5) begin
      tick();
      if (vd.frame_start) fs_cnt++;
    end
    chk("def_midrst_fs_during", fs_cnt, 0);
    chk("def_midrst_hold_hpos", int'(vd.hpos), 799);
    @(negedge clk);
    rst_n_def = 1'b1;
    edges = 0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      edges++;
      if (vd.frame_start) found = 1'b1;
    end
    chk("def_midrst_fs_found", int'(found), 1);
    chk("def_midrst_fs_edges", edges, 2);

    // ---------------- small mode: vector table ----------------
    for (int i = 0; i < NV; i++) begin
      if (i == 1) begin
        @(negedge clk);
        rst_n_sml = 1'b1;
      end
      repeat (tbl[i].edges) tick();
      if (int'(vsm.hpos) !== tbl[i].hpos || int'(vsm.vpos) !== tbl[i].vpos ||
          int'(vsm.display_on) !== tbl[i].disp || int'(vsm.hsync) !== tbl[i].hs ||
          int'(vsm.vsync) !== tbl[i].vs || int'(vsm.pixel_clk) !== tbl[i].pclk ||
          int'(vsm.pixel_en) !== tbl[i].pen || int'(vsm.line_start) !== tbl[i].ls ||
          int'(vsm.frame_start) !== tbl[i].fs) begin
        $display("FAIL sml_vec%0d: got h%0d v%0d d%0d hs%0d vs%0d pc%0d pe%0d ls%0d fs%0d expected h%0d v%0d d%0d hs%0d vs%0d pc%0d pe%0d ls%0d fs%0d",
                 i, vsm.hpos, vsm.vpos, vsm.display_on, vsm.hsync, vsm.vsync,
                 vsm.pixel_clk, vsm.pixel_en, vsm.line_start, vsm.frame_start,
                 tbl[i].hpos, tbl[i].vpos, tbl[i].disp, tbl[i].hs, tbl[i].vs,
                 tbl[i].pclk, tbl[i].pen, tbl[i].ls, tbl[i].fs);
        n_err++;
      end
      n_vec++;
    end

    // ---------------- small mode: three whole frames ----------------
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (vsm.frame_start) found = 1'b1;
      else tick();
    end
    chk("sml_wait_fs", int'(found), 1);
    fs_cnt = 0; ls_cnt = 0; disp_cnt = 0; pclk_hi = 0; hs_low = 0;
    dbl_ls = 0; dbl_fs = 0; fs2_at = -1; prev_ls = 1'b0; prev_fs = 1'b0;
    for (int c = 0; c < 432; c++) begin
      if (vsm.frame_start) begin
        fs_cnt++;
        if (fs_cnt == 2) fs2_at = c;
      end
      if (vsm.line_start) ls_cnt++;
      if (vsm.display_on) disp_cnt++;
      if (vsm.pixel_clk) pclk_hi++;
      if (vsm.hsync) hs_low++;
      if (vsm.line_start && prev_ls) dbl_ls++;
      if (vsm.frame_start && prev_fs) dbl_fs++;
      prev_ls = vsm.line_start;
      prev_fs = vsm.frame_start;
      tick();
    end
    chk("sml_fs_count", fs_cnt, 3);
    chk("sml_ls_count", ls_cnt, 18);
    chk("sml_frame_period", fs2_at, 144);
    chk("sml_disp_clks", disp_cnt, 108);
    chk("sml_pclk_high_clks", pclk_hi, 288);
    chk("sml_hsync_high_clks", hs_low, 108);
    chk("sml_ls_wide", dbl_ls, 0);
    chk("sml_fs_wide", dbl_fs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
